oled_init_seq: RTL and testbench
================================

# oled_init_seq

Power-up and initialisation sequencer for the ZedboardOLED SSD1306 panel, sitting directly upstream of the SPI byte sender. On START it brings up VDD, pulses the panel reset, enables the charge pump, brings up VBAT and issues the fixed command list. Each byte is issued over the sender's SPI_EN / SPI_DATA / SPI_FIN handshake with DC held low. It owns the panel's DC, RES, VBAT and VDD pins and reports BUSY/DONE to the display controller.

## Interface
- CLKS_PER_MS, 100000, CLK cycles per millisecond. Minimum 2. All delays are integer multiples of this value.
- CLK  in  1  system clock; all logic on rising edge
- RST  in  1  reset RST, synchronous, active-high; clock CLK
- START  in  1  level; sampled only in IDLE; a 1 there begins the sequence
- SPI_EN  out  1  byte request to SPI sender
- SPI_DATA  out  8  byte to send; stable whenever SPI_EN=1 and one cycle before it rises
- SPI_FIN  in  1  byte-complete from SPI sender
- DC  out  1  panel data/command select; 0=command
- RES  out  1  panel reset, active low
- VBAT  out  1  panel VBAT enable, active low
- VDD  out  1  panel VDD enable, active low
- BUSY  out  1  1 from leaving IDLE until DONE
- DONE  out  1  sequence complete; sticky until RST

## Operation
- Reset values: SPI_EN=0, SPI_DATA=0x00, DC=0, RES=1, VBAT=1, VDD=1, BUSY=0, DONE=0. State is IDLE. The delay counter and byte index are 0.
- Sequence:
  1. VDD<=0, then wait 1 ms.
  2. Send 0xAE.
  3. RES<=0, wait 1 ms; RES<=1, wait 1 ms.
  4. Send 0x8D, 0x14, 0xD9, 0xF1.
  5. VBAT<=0, then wait 100 ms.
  6. Send 0xA1, 0xC8, 0xDA, 0x20, 0x20, 0x00, 0xAF.
  7. Optional clear (see Configuration).
  8. DONE.
- Command bytes come from an internal 12-entry ROM indexed by a 4-bit counter. Segment boundaries are at indices 1, 5 and 12.
- States: IDLE, VDD_ON, DLY, CMD_LOAD, CMD_REQ, CMD_WFIN, CMD_WCLR, RES_LO, RES_HI, VBAT_ON, CLR_LOAD, CLR_REQ, CLR_WFIN, CLR_WCLR, FIN. A next-state register records where DLY returns to.
- Byte handshake, per byte:
  - LOAD drives SPI_DATA.
  - REQ sets SPI_EN=1.
  - WFIN holds SPI_EN=1 until SPI_FIN=1, then drives SPI_EN=0.
  - WCLR waits for SPI_FIN=0, then advances the index.
  - SPI_EN never re-asserts while SPI_FIN=1.
- Delay counter width is $clog2(100*CLKS_PER_MS+1). It counts down from N*CLKS_PER_MS-1, and DLY exits on the cycle the counter reads 0.
- START is ignored in all states except IDLE. FIN is terminal; re-initialisation requires RST.
- RST mid-sequence forces all reset values on the next edge, including VDD=1 and VBAT=1 (immediate power removal). SPI_EN drops the same edge.
- There is no SPI_FIN timeout; a stuck handshake holds the state indefinitely.

## Timing
- START=1 in IDLE at edge k: BUSY=1 and VDD=0 after edge k+1.
- The delay after an output change spans exactly N*CLKS_PER_MS cycles before the next output change or SPI_DATA load.
- SPI_DATA is valid 1 cycle before SPI_EN rises.
- SPI_EN falls 1 cycle after SPI_FIN is sampled high.
- The next SPI_EN rise is ≥2 cycles after SPI_FIN is sampled low.
- DONE=1 and BUSY=0 on the edge after the last byte's SPI_FIN is sampled low.

## Configuration
- OLED_INIT_CLEAR_EN defined:
  - After 0xAF, DC<=1 and 512 bytes of 0x00 are sent, clearing the 128x32 GDDRAM under horizontal addressing (0x20 0x00).
  - The clear uses a 10-bit counter with the same handshake as command bytes.
  - DC returns to 0 before FIN.
- OLED_INIT_CLEAR_EN undefined: the CLR_* states and counter are absent, and FIN follows the 0xAF byte directly. DC stays 0 throughout.

## Test plan
- Reset: hold RST 3 cycles with START=1 → all outputs at reset values, BUSY=0, no SPI_EN pulse.
- Full sequence, CLKS_PER_MS=10, SPI model raising SPI_FIN 20 cycles after SPI_EN and clearing it 1 cycle after SPI_EN falls:
  - Bytes appear in the order AE,8D,14,D9,F1,A1,C8,DA,20,20,00,AF, all with DC=0.
  - VDD→0 precedes 0xAE by 10 cycles.
  - RES low for exactly 10 cycles.
  - VBAT→0 precedes 0xA1 by 1000 cycles.
  - DONE=1 after the last FIN.
- START toggled during the VBAT wait and after DONE → no effect. The sequence is unchanged and no extra bytes are sent.
- RST asserted mid-byte (SPI_EN=1, waiting on SPI_FIN) → next edge SPI_EN=0, VDD=1, VBAT=1, RES=1. A subsequent START replays the sequence from step 1.
- SPI_FIN held 0 for 5000 cycles → SPI_EN stays 1, BUSY=1, no state advance. Releasing SPI_FIN resumes normally.
- OLED_INIT_CLEAR_EN defined → after 0xAF, exactly 512 bytes of 0x00 with DC=1, then DC=0 and DONE=1. Undefined → DC never 1.

Source files
------------

// File: rtl/oled_init_seq.sv
// SSD1306 power-up and command sequencer feeding the SPI byte sender.
// Define OLED_INIT_CLEAR_EN to append a 512-byte GDDRAM clear (DC=1) after the command list.
module oled_init_seq #(
    parameter int unsigned CLKS_PER_MS = 100000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    output logic       SPI_EN,
    output logic [7:0] SPI_DATA,
    input  logic       SPI_FIN,
    output logic       DC,
    output logic       RES,
    output logic       VBAT,
    output logic       VDD,
    output logic       BUSY,
    output logic       DONE
);
    localparam int unsigned CntW = $clog2(100 * CLKS_PER_MS + 1);
    localparam logic [CntW-1:0] Dly1Ms   = CntW'(CLKS_PER_MS - 1);
    localparam logic [CntW-1:0] Dly100Ms = CntW'(100 * CLKS_PER_MS - 1);

    typedef enum logic [3:0] {
        StIdle, StVddOn, StDly, StCmdLoad, StCmdReq, StCmdWfin, StCmdWclr,
        StResLo, StResHi, StVbatOn,
`ifdef OLED_INIT_CLEAR_EN
        StClrLoad, StClrReq, StClrWfin, StClrWclr,
`endif
        StFin
    } state_e;

    state_e          state_q, state_d, ret_q, ret_d, act_state;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      idx_q, idx_d;
    logic [7:0]      spi_data_q, spi_data_d;
    logic            spi_en_q, spi_en_d, dc_q, dc_d, res_q, res_d;
    logic            vbat_q, vbat_d, vdd_q, vdd_d, busy_q, busy_d, done_q, done_d;
`ifdef OLED_INIT_CLEAR_EN
    logic [9:0]      clr_q, clr_d;
`endif

    function automatic logic [7:0] cmd_rom(input logic [3:0] i);
        case (i)
            4'd0:    cmd_rom = 8'hAE;
            4'd1:    cmd_rom = 8'h8D;
            4'd2:    cmd_rom = 8'h14;
            4'd3:    cmd_rom = 8'hD9;
            4'd4:    cmd_rom = 8'hF1;
            4'd5:    cmd_rom = 8'hA1;
            4'd6:    cmd_rom = 8'hC8;
            4'd7:    cmd_rom = 8'hDA;
            4'd8:    cmd_rom = 8'h20;
            4'd9:    cmd_rom = 8'h20;
            4'd10:   cmd_rom = 8'h00;
            4'd11:   cmd_rom = 8'hAF;
            default: cmd_rom = 8'h00;
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        spi_data_d = spi_data_q;
        spi_en_d   = spi_en_q;
        dc_d       = dc_q;
        res_d      = res_q;
        vbat_d     = vbat_q;
        vdd_d      = vdd_q;
        busy_d     = busy_q;
        done_d     = done_q;
`ifdef OLED_INIT_CLEAR_EN
        clr_d      = clr_q;
`endif
        // On its final cycle DLY performs the return state's action directly, so a
        // delay spans exactly N ms between the two output changes.
        act_state = (state_q == StDly && cnt_q == '0) ? ret_q : state_q;

        case (act_state)
            StIdle: if (START) state_d = StVddOn;
            StVddOn: begin
                vdd_d   = 1'b0;
                busy_d  = 1'b1;
                cnt_d   = Dly1Ms;
                ret_d   = StCmdLoad;
                state_d = StDly;
            end
            StDly: cnt_d = cnt_q - CntW'(1);
            StCmdLoad: begin
                spi_data_d = cmd_rom(idx_q);
                state_d    = StCmdReq;
            end
            StCmdReq: begin
                spi_en_d = 1'b1;
                state_d  = StCmdWfin;
            end
            StCmdWfin: if (SPI_FIN) begin
                spi_en_d = 1'b0;
                state_d  = StCmdWclr;
            end
            StCmdWclr: if (!SPI_FIN) begin
                idx_d = idx_q + 4'd1;
                case (idx_q + 4'd1)
                    4'd1:    state_d = StResLo;
                    4'd5:    state_d = StVbatOn;
                    4'd12: begin
`ifdef OLED_INIT_CLEAR_EN
                        state_d = StClrLoad;
`else
                        state_d = StFin;
`endif
                    end
                    default: state_d = StCmdLoad;
                endcase
            end
            StResLo: begin
                res_d   = 1'b0;
                cnt_d   = Dly1Ms;
                ret_d   = StResHi;
                state_d = StDly;
            end
            StResHi: begin
                res_d   = 1'b1;
                cnt_d   = Dly1Ms;
                ret_d   = StCmdLoad;
                state_d = StDly;
            end
            StVbatOn: begin
                vbat_d  = 1'b0;
                cnt_d   = Dly100Ms;
                ret_d   = StCmdLoad;
                state_d = StDly;
            end
`ifdef OLED_INIT_CLEAR_EN
            StClrLoad: begin
                spi_data_d = 8'h00;
                dc_d       = 1'b1;
                state_d    = StClrReq;
            end
            StClrReq: begin
                spi_en_d = 1'b1;
                state_d  = StClrWfin;
            end
            StClrWfin: if (SPI_FIN) begin
                spi_en_d = 1'b0;
                state_d  = StClrWclr;
            end
            StClrWclr: if (!SPI_FIN) begin
                clr_d = clr_q + 10'd1;
                if (clr_q == 10'd511) begin
                    dc_d    = 1'b0;
                    state_d = StFin;
                end else begin
                    state_d = StClrLoad;
                end
            end
`endif
            StFin: begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            ret_q      <= StIdle;
            cnt_q      <= '0;
            idx_q      <= 4'd0;
            spi_data_q <= 8'h00;
            spi_en_q   <= 1'b0;
            dc_q       <= 1'b0;
            res_q      <= 1'b1;
            vbat_q     <= 1'b1;
            vdd_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef OLED_INIT_CLEAR_EN
            clr_q      <= 10'd0;
`endif
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            spi_data_q <= spi_data_d;
            spi_en_q   <= spi_en_d;
            dc_q       <= dc_d;
            res_q      <= res_d;
            vbat_q     <= vbat_d;
            vdd_q      <= vdd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef OLED_INIT_CLEAR_EN
            clr_q      <= clr_d;
`endif
        end
    end

    assign SPI_EN   = spi_en_q;
    assign SPI_DATA = spi_data_q;
    assign DC       = dc_q;
    assign RES      = res_q;
    assign VBAT     = vbat_q;
    assign VDD      = vdd_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
endmodule

// File: tb/tb_oled_init_seq.sv
// Scoreboard bench for oled_init_seq: randomized SPI_FIN latency, START noise, mid-byte
// reset and a long SPI_FIN stall, checked against a list/arithmetic reference model.
module tb_oled_init_seq;
    localparam int unsigned CPM = 10;
    localparam int NCMD = 12;
`ifdef OLED_INIT_CLEAR_EN
    localparam int NCLR = 512;
`else
    localparam int NCLR = 0;
`endif

    logic       CLK = 1'b0;
    logic       RST, START, SPI_EN, SPI_FIN, DC, RES, VBAT, VDD, BUSY, DONE;
    logic [7:0] SPI_DATA;

    always #5 CLK = ~CLK;

    oled_init_seq #(.CLKS_PER_MS(CPM)) dut (
        .CLK(CLK), .RST(RST), .START(START), .SPI_EN(SPI_EN), .SPI_DATA(SPI_DATA),
        .SPI_FIN(SPI_FIN), .DC(DC), .RES(RES), .VBAT(VBAT), .VDD(VDD), .BUSY(BUSY),
        .DONE(DONE)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       dc;
    } exp_t;

    logic [7:0] cmd_list [NCMD] = '{8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1, 8'hA1,
                                    8'hC8, 8'hDA, 8'h20, 8'h20, 8'h00, 8'hAF};
    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   base_delay = 20;
    bit   rand_delay = 1'b0;
    int   stall_byte = -1;
    bit   stalling = 1'b0;
    int   cyc = 0;
    int   mon_b = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // SPI sender model: FIN rises a programmable number of cycles after EN, clears one
    // cycle after EN has dropped.
    initial begin : spi_model
        int timer;
        bit armed;
        bit clr_wait;
        int byte_no;
        timer = 0; armed = 1'b0; clr_wait = 1'b0; byte_no = 0;
        SPI_FIN = 1'b0;
        forever begin
            @(posedge CLK); #1;
            if (RST) begin
                armed = 1'b0; clr_wait = 1'b0; byte_no = 0; SPI_FIN = 1'b0; stalling = 1'b0;
            end else if (armed) begin
                if (timer > 1) timer--;
                else begin
                    SPI_FIN = 1'b1; armed = 1'b0; stalling = 1'b0;
                end
            end else if (SPI_FIN && !SPI_EN) begin
                if (clr_wait) begin
                    SPI_FIN = 1'b0; clr_wait = 1'b0;
                end else clr_wait = 1'b1;
            end else if (SPI_EN && !SPI_FIN) begin
                armed = 1'b1;
                if (byte_no == stall_byte) begin
                    timer = 5000; stalling = 1'b1;
                end else if (byte_no >= NCMD) timer = $urandom_range(3, 1);
                else if (rand_delay) timer = $urandom_range(25, 1);
                else timer = base_delay;
                byte_no++;
            end
        end
    end

    // Monitor: pops the scoreboard on every SPI_EN rise and checks spacing rules.
    initial begin : monitor
        exp_t e;
        int t_vdd, t_resl, t_resh, t_vbat, t_fin_rise, t_fin_low;
        logic p_en, p_fin, p_vdd, p_res, p_vbat, p_done;
        logic [7:0] p_data;
        t_vdd = 0; t_resl = 0; t_resh = 0; t_vbat = 0; t_fin_rise = 0; t_fin_low = 0;
        p_en = 1'b0; p_fin = 1'b0; p_vdd = 1'b1; p_res = 1'b1; p_vbat = 1'b1; p_done = 1'b0;
        p_data = 8'h00;
        forever begin
            @(posedge CLK); #2;
            cyc++;
            if (RST) mon_b = 0;
            else begin
                if (p_vdd && !VDD) t_vdd = cyc;
                if (p_res && !RES) t_resl = cyc;
                if (!p_res && RES) begin
                    t_resh = cyc;
                    chk("res_low_len", cyc - t_resl, CPM);
                end
                if (p_vbat && !VBAT) t_vbat = cyc;
                if (!p_fin && SPI_FIN) t_fin_rise = cyc;
                if (p_fin && !SPI_FIN) t_fin_low = cyc;
                if (p_en && !SPI_EN) chk("en_fall_lat", cyc - t_fin_rise, 1);
                if (!p_en && SPI_EN) begin
                    chk("data_setup", SPI_DATA, p_data);
                    chk("fin_low_at_req", SPI_FIN, 0);
                    if (mon_b > 0) chk("req_gap", (cyc - t_fin_low) >= 3, 1);
                    if (mon_b == 0) chk("vdd_to_first", (cyc - 1) - t_vdd, CPM);
                    if (mon_b == 1) chk("res_to_cmd", (cyc - 1) - t_resh, CPM);
                    if (mon_b == 5) chk("vbat_to_cmd", (cyc - 1) - t_vbat, 100 * CPM);
                    chk("byte_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("byte_data", SPI_DATA, e.data);
                        chk("byte_dc", DC, e.dc);
                    end
                    mon_b++;
                end
                if (!p_done && DONE) chk("done_lat", cyc - t_fin_low, 2);
            end
            p_en = SPI_EN; p_fin = SPI_FIN; p_vdd = VDD; p_res = RES; p_vbat = VBAT;
            p_done = DONE; p_data = SPI_DATA;
        end
    end

    task automatic do_start();
        exp_t e;
        for (int i = 0; i < NCMD; i++) begin
            e.data = cmd_list[i]; e.dc = 1'b0; exp_q.push_back(e);
        end
        for (int i = 0; i < NCLR; i++) begin
            e.data = 8'h00; e.dc = 1'b1; exp_q.push_back(e);
        end
        START = 1'b1;
        @(posedge CLK); #3;
        chk("start_busy_k", BUSY, 0);
        @(posedge CLK); #3;
        chk("start_busy_k1", BUSY, 1);
        chk("start_vdd_k1", VDD, 0);
        START = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit toggle);
        int n;
        n = 0;
        while (!DONE && n < budget) begin
            @(negedge CLK);
            if (toggle) START = ($urandom_range(1, 0) != 0);
            n++;
        end
        chk("done_reached", DONE, 1);
        chk("busy_clear", BUSY, 0);
        chk("dc_final", DC, 0);
        chk("queue_drained", exp_q.size(), 0);
        chk("byte_count", mon_b, NCMD + NCLR);
        START = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge CLK); RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
    endtask

    initial begin : stim
        int k, n;
        RST = 1'b1; START = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #3;
            chk("rst_outputs", {SPI_EN, SPI_DATA, DC, RES, VBAT, VDD, BUSY, DONE},
                {1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
        end
        @(negedge CLK); RST = 1'b0; START = 1'b0;
        repeat (5) @(negedge CLK);
        chk("idle_hold", {SPI_EN, BUSY, VDD}, 3'b001);

        // Full sequence with fixed 20-cycle FIN latency and START noise throughout.
        base_delay = 20; rand_delay = 1'b0;
        do_start();
        wait_done(30000, 1'b1);
        repeat (100) begin
            @(negedge CLK); START = ($urandom_range(1, 0) != 0);
        end
        START = 1'b0;
        chk("post_done_sticky", {DONE, BUSY}, 2'b10);
        chk("post_done_bytes", mon_b, NCMD + NCLR);

        // Reset while a byte waits on SPI_FIN, then replay.
        pulse_reset();
        rand_delay = 1'b1;
        k = $urandom_range(NCMD - 1, 0);
        do_start();
        n = 0;
        while (!(mon_b == k + 1 && SPI_EN && !SPI_FIN) && n < 5000) begin
            @(negedge CLK); n++;
        end
        chk("reached_byte", mon_b, k + 1);
        RST = 1'b1;
        @(posedge CLK); #3;
        chk("midrst_outputs", {SPI_EN, VDD, VBAT, RES, BUSY, DONE}, 6'b011100);
        exp_q.delete();
        @(negedge CLK); RST = 1'b0;
        repeat (40) @(negedge CLK);
        chk("midrst_idle", {SPI_EN, BUSY}, 2'b00);
        do_start();
        wait_done(30000, 1'b0);

        // SPI_FIN stuck low for 5000 cycles on a random byte.
        pulse_reset();
        stall_byte = $urandom_range(NCMD - 1, 0);
        do_start();
        n = 0;
        while (!stalling && n < 5000) begin
            @(negedge CLK); n++;
        end
        repeat (4000) @(negedge CLK);
        chk("stall_en", SPI_EN, 1);
        chk("stall_busy", BUSY, 1);
        chk("stall_fin", SPI_FIN, 0);
        chk("stall_idx", mon_b, stall_byte + 1);
        chk("stall_data", SPI_DATA, cmd_list[stall_byte]);
        wait_done(30000, 1'b0);
        stall_byte = -1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
